// File: rtl/hiscore_pkg.sv
// Shared definitions for the hiscore upload/load blocks: FSM states, the
// out-of-range fill byte and per-game default geometry.
package hiscore_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PAUSE,
      ST_READY,
      ST_FETCH
   } hs_state_t;

   localparam logic [7:0] OOR_BYTE = 8'hFF;

   localparam int HS_ADDR_W = 10;
   localparam int HS_LEN    = 1024;
   localparam int HS_RD_LAT = 1;

endpackage

// File: rtl/hiscore_upload.sv
// Serves HPS save-file upload reads from the shared hiscore RAM port, pausing
// the CPU for the session and stretching each ioctl_rd with ioctl_wait.
module hiscore_upload
   import hiscore_pkg::*;
#(
   parameter int ADDR_W = HS_ADDR_W,
   parameter int LEN    = HS_LEN,
   parameter int RD_LAT = HS_RD_LAT
)(
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_upload,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic              pause_req,
   input  logic              pause_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic [ADDR_W:0]   bytes_sent,
   output logic              proto_err
);

   localparam logic [24:0]     LEN_ADDR = 25'(LEN);
   localparam logic [ADDR_W:0] LEN_CNT  = (ADDR_W+1)'(LEN);
   localparam logic [1:0]      LAT_CNT  = 2'(RD_LAT);

   hs_state_t         state, state_n;
   logic              upload_d;
   logic              pend, pend_n;
   logic [24:0]       pend_addr, pend_addr_n;
   logic              restart, restart_n;
   logic [1:0]        lat_cnt, lat_cnt_n;
   logic [7:0]        din_n;
   logic              wait_n, pause_req_n, mem_rd_n, proto_err_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic [ADDR_W:0]   bytes_n;
   logic              upload_rise, upload_fall;
   logic              req;
   logic [24:0]       req_addr;

   assign upload_rise = ioctl_upload & ~upload_d;
   assign upload_fall = ~ioctl_upload & upload_d;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= ST_IDLE;
         upload_d   <= 1'b0;
         pend       <= 1'b0;
         pend_addr  <= '0;
         restart    <= 1'b0;
         lat_cnt    <= '0;
         ioctl_din  <= '0;
         ioctl_wait <= 1'b0;
         pause_req  <= 1'b0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         bytes_sent <= '0;
         proto_err  <= 1'b0;
      end else begin
         state      <= state_n;
         upload_d   <= ioctl_upload;
         pend       <= pend_n;
         pend_addr  <= pend_addr_n;
         restart    <= restart_n;
         lat_cnt    <= lat_cnt_n;
         ioctl_din  <= din_n;
         ioctl_wait <= wait_n;
         pause_req  <= pause_req_n;
         mem_rd     <= mem_rd_n;
         mem_addr   <= mem_addr_n;
         bytes_sent <= bytes_n;
         proto_err  <= proto_err_n;
      end
   end

   always_comb begin
      state_n     = state;
      pend_n      = pend;
      pend_addr_n = pend_addr;
      restart_n   = restart;
      lat_cnt_n   = lat_cnt;
      din_n       = ioctl_din;
      wait_n      = ioctl_wait;
      pause_req_n = pause_req;
      mem_rd_n    = 1'b0;
      mem_addr_n  = mem_addr;
      bytes_n     = bytes_sent;
      proto_err_n = proto_err;
      req         = 1'b0;
      req_addr    = ioctl_addr;

      if (upload_fall) begin
         state_n     = ST_IDLE;
         wait_n      = 1'b0;
         pause_req_n = 1'b0;
         pend_n      = 1'b0;
         restart_n   = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (upload_rise) begin
                  pause_req_n = 1'b1;
                  bytes_n     = '0;
                  proto_err_n = 1'b0;
                  pend_n      = 1'b0;
                  state_n     = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (pause_ack) begin
                  state_n = ST_READY;
                  wait_n  = 1'b0;
                  if (pend) begin
                     req      = 1'b1;
                     req_addr = pend_addr;
                     pend_n   = 1'b0;
                     if (ioctl_rd)
                        proto_err_n = 1'b1;
                  end else if (ioctl_rd) begin
                     req = 1'b1;
                  end
               end else if (ioctl_rd) begin
                  // Only one read can be parked while the CPU is still running.
                  if (pend) begin
                     proto_err_n = 1'b1;
                  end else begin
                     pend_n      = 1'b1;
                     pend_addr_n = ioctl_addr;
                     wait_n      = 1'b1;
                  end
               end
            end
            ST_READY: begin
               wait_n = ~pause_ack;
               req    = ioctl_rd;
            end
            ST_FETCH: begin
               wait_n = 1'b1;
               if (ioctl_rd)
                  proto_err_n = 1'b1;
               // Losing the grant voids the read in flight; it is reissued once ack returns.
               if (!pause_ack) begin
                  restart_n = 1'b1;
                  lat_cnt_n = '0;
               end else if (restart) begin
                  mem_rd_n  = 1'b1;
                  restart_n = 1'b0;
                  lat_cnt_n = '0;
               end else if (lat_cnt == LAT_CNT) begin
                  din_n   = mem_data;
                  wait_n  = 1'b0;
                  bytes_n = (bytes_sent == LEN_CNT) ? bytes_sent : bytes_sent + 1'b1;
                  state_n = ST_READY;
               end else begin
                  lat_cnt_n = lat_cnt + 2'd1;
               end
            end
            default: state_n = ST_IDLE;
         endcase

         if (req) begin
            if (req_addr < LEN_ADDR) begin
               state_n    = ST_FETCH;
               mem_addr_n = req_addr[ADDR_W-1:0];
               mem_rd_n   = pause_ack;
               restart_n  = ~pause_ack;
               lat_cnt_n  = '0;
               wait_n     = 1'b1;
            end else begin
               din_n = OOR_BYTE;
            end
         end
      end
   end

endmodule

// File: tb/tb_hiscore_upload.sv
// Directed bench for hiscore_upload: a default instance (RD_LAT=1, LEN=1024)
// and a second one (RD_LAT=2, LEN=4) driven by the same inputs.
module tb_hiscore_upload;

   logic        clk;
   logic        reset;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic        pause_ack;

   logic [7:0]  a_din, b_din;
   logic        a_wait, b_wait;
   logic        a_pause_req, b_pause_req;
   logic [9:0]  a_mem_addr, b_mem_addr;
   logic        a_mem_rd, b_mem_rd;
   logic [7:0]  a_mem_data, b_mem_data;
   logic [10:0] a_bytes, b_bytes;
   logic        a_proto_err, b_proto_err;

   logic [7:0]  ram [0:1023];
   logic [7:0]  a_s1, b_s1, b_s2;
   int          a_rd_cnt;
   int          checks;
   int          passed;

   typedef struct {
      logic [24:0] addr;
      logic [7:0]  din;
      logic        wait1;
      int          lat;
      logic [10:0] bytes;
   } vec_t;

   vec_t vecs [7];

   hiscore_upload dut_a (
      .clk_sys(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
      .ioctl_addr(ioctl_addr), .ioctl_din(a_din), .ioctl_wait(a_wait),
      .pause_req(a_pause_req), .pause_ack(pause_ack), .mem_addr(a_mem_addr),
      .mem_rd(a_mem_rd), .mem_data(a_mem_data), .bytes_sent(a_bytes), .proto_err(a_proto_err)
   );

   hiscore_upload #(.ADDR_W(10), .LEN(4), .RD_LAT(2)) dut_b (
      .clk_sys(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
      .ioctl_addr(ioctl_addr), .ioctl_din(b_din), .ioctl_wait(b_wait),
      .pause_req(b_pause_req), .pause_ack(pause_ack), .mem_addr(b_mem_addr),
      .mem_rd(b_mem_rd), .mem_data(b_mem_data), .bytes_sent(b_bytes), .proto_err(b_proto_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM model: data appears for exactly one cycle, RD_LAT cycles after mem_rd.
   always @(posedge clk) begin
      a_s1 <= a_mem_rd ? ram[a_mem_addr] : 8'hEE;
      b_s1 <= b_mem_rd ? ram[b_mem_addr] : 8'hEE;
      b_s2 <= b_s1;
      if (a_mem_rd)
         a_rd_cnt <= a_rd_cnt + 1;
   end

   assign a_mem_data = a_s1;
   assign b_mem_data = b_s2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rd, input logic [24:0] addr);
      ioctl_rd   = rd;
      ioctl_addr = addr;
      tick();
      ioctl_rd   = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      else
         passed++;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_din"}, a_din, 0);
      checkOutput({tag, "_wait"}, a_wait, 0);
      checkOutput({tag, "_pause_req"}, a_pause_req, 0);
      checkOutput({tag, "_mem_rd"}, a_mem_rd, 0);
      checkOutput({tag, "_mem_addr"}, a_mem_addr, 0);
      checkOutput({tag, "_bytes"}, a_bytes, 0);
      checkOutput({tag, "_proto_err"}, a_proto_err, 0);
      checkOutput({tag, "_b_pause_req"}, b_pause_req, 0);
      checkOutput({tag, "_b_din"}, b_din, 0);
   endtask

   initial begin
      int          rd_snap;
      logic [24:0] seq_addr [6];
      logic [7:0]  exp_a    [6];
      logic [7:0]  exp_b    [6];

      checks = 0;
      passed = 0;
      a_rd_cnt = 0;
      for (int i = 0; i < 1024; i++)
         ram[i] = 8'(i * 17);

      vecs[0] = '{25'd0,        8'h00, 1'b1, 3, 11'd1};
      vecs[1] = '{25'd1,        8'h11, 1'b1, 3, 11'd2};
      vecs[2] = '{25'd2,        8'h22, 1'b1, 3, 11'd3};
      vecs[3] = '{25'd3,        8'h33, 1'b1, 3, 11'd4};
      vecs[4] = '{25'd1024,     8'hFF, 1'b0, 1, 11'd4};
      vecs[5] = '{25'h1FFFFFF,  8'hFF, 1'b0, 1, 11'd4};
      vecs[6] = '{25'd1023,     8'hEF, 1'b1, 3, 11'd5};

      reset = 1'b1;
      ioctl_upload = 1'b0;
      ioctl_rd = 1'b0;
      ioctl_addr = '0;
      pause_ack = 1'b0;
      repeat (3) tick();
      checkResetValues("reset");
      reset = 1'b0;
      tick();

      $display("[TB] session 1: in-range and out-of-range reads");
      ioctl_upload = 1'b1;
      tick();
      checkOutput("pause_req_rise", a_pause_req, 1);
      repeat (4) tick();
      pause_ack = 1'b1;
      tick();
      foreach (vecs[i]) begin
         applyStimulus(1'b1, vecs[i].addr);
         checkOutput($sformatf("v%0d_wait_t1", i), a_wait, vecs[i].wait1);
         for (int k = 1; k < vecs[i].lat; k++)
            tick();
         checkOutput($sformatf("v%0d_din", i), a_din, vecs[i].din);
         checkOutput($sformatf("v%0d_wait_done", i), a_wait, 0);
         checkOutput($sformatf("v%0d_bytes", i), a_bytes, vecs[i].bytes);
      end

      $display("[TB] session 2: read parked in PAUSE");
      ioctl_upload = 1'b0;
      pause_ack = 1'b0;
      tick();
      checkOutput("pause_req_fall", a_pause_req, 0);
      ioctl_upload = 1'b1;
      tick();
      checkOutput("bytes_cleared", a_bytes, 0);
      applyStimulus(1'b1, 25'd7);
      checkOutput("pend_wait_t1", a_wait, 1);
      for (int k = 0; k < 9; k++) begin
         tick();
         checkOutput($sformatf("pend_wait_hold%0d", k), a_wait, 1);
      end
      pause_ack = 1'b1;
      tick();
      checkOutput("pend_mem_rd", a_mem_rd, 1);
      checkOutput("pend_mem_addr", a_mem_addr, 7);
      tick();
      checkOutput("pend_wait_ack2", a_wait, 1);
      tick();
      checkOutput("pend_din", a_din, 8'h77);
      checkOutput("pend_wait_done", a_wait, 0);
      checkOutput("pend_bytes", a_bytes, 1);

      $display("[TB] back-to-back read sets proto_err");
      rd_snap = a_rd_cnt;
      applyStimulus(1'b1, 25'd2);
      applyStimulus(1'b1, 25'd3);
      checkOutput("proto_err", a_proto_err, 1);
      tick();
      checkOutput("proto_din", a_din, 8'h22);
      checkOutput("proto_wait", a_wait, 0);
      checkOutput("proto_bytes", a_bytes, 2);
      repeat (2) tick();
      checkOutput("proto_mem_rd_count", a_rd_cnt - rd_snap, 1);

      $display("[TB] upload falls during FETCH");
      rd_snap = a_rd_cnt;
      applyStimulus(1'b1, 25'd5);
      ioctl_upload = 1'b0;
      tick();
      checkOutput("abort_wait", a_wait, 0);
      checkOutput("abort_pause_req", a_pause_req, 0);
      checkOutput("abort_mem_rd", a_mem_rd, 0);
      repeat (3) tick();
      checkOutput("abort_din_held", a_din, 8'h22);
      checkOutput("abort_bytes_held", a_bytes, 2);
      checkOutput("abort_mem_rd_count", a_rd_cnt - rd_snap, 1);

      $display("[TB] session 3: grant lost during FETCH");
      ioctl_upload = 1'b1;
      repeat (2) tick();
      rd_snap = a_rd_cnt;
      applyStimulus(1'b1, 25'd9);
      pause_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput($sformatf("fault_wait%0d", k), a_wait, 1);
      end
      checkOutput("fault_din_held", a_din, 8'h22);
      pause_ack = 1'b1;
      tick();
      checkOutput("fault_reissue", a_mem_rd, 1);
      repeat (2) tick();
      checkOutput("fault_din", a_din, 8'h99);
      checkOutput("fault_wait_done", a_wait, 0);
      checkOutput("fault_bytes", a_bytes, 1);
      checkOutput("fault_mem_rd_count", a_rd_cnt - rd_snap, 2);

      $display("[TB] reset during FETCH, then RD_LAT=2 session");
      applyStimulus(1'b1, 25'd3);
      reset = 1'b1;
      ioctl_upload = 1'b0;
      tick();
      checkResetValues("midreset");
      reset = 1'b0;
      tick();
      ioctl_upload = 1'b1;
      repeat (2) tick();
      seq_addr = '{25'd0, 25'd1, 25'd2, 25'd3, 25'd0, 25'd4};
      exp_a    = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h44};
      exp_b    = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'hFF};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, seq_addr[i]);
         repeat (2) tick();
         checkOutput($sformatf("s%0d_a_din", i), a_din, exp_a[i]);
         checkOutput($sformatf("s%0d_b_wait_t3", i), b_wait, (i == 5) ? 0 : 1);
         tick();
         checkOutput($sformatf("s%0d_b_din", i), b_din, exp_b[i]);
         checkOutput($sformatf("s%0d_b_wait_t4", i), b_wait, 0);
      end
      checkOutput("b_bytes_saturated", b_bytes, 4);
      checkOutput("a_bytes_final", a_bytes, 6);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
